hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32 core. It sits beside the forwarding unit and drives all pipeline stall and flush enables.
- Covers four hazard sources: load-use hazards (which forwarding cannot cover), multi-cycle MDU operations in EX, data-memory wait states, and taken-branch flushes.
- Owns the MDU start/done handshake and keeps stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- MDU_TIMEOUT, 64, maximum MDU busy cycles before the error is raised.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs1_addr  in  REG_AW  rs1 address of the instruction in ID.
- id_rs2_addr  in  REG_AW  rs2 address of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd_addr  in  REG_AW  destination register of the EX instruction.
- ex_is_mdu  in  1  EX instruction is a mul/div.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mdu_done  in  1  MDU result valid (single-cycle pulse).
- mem_req  in  1  MEM stage is doing a load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_stall  out  1  hold MEM/WB.
- if_id_flush  out  1  zero IF/ID.
- id_ex_flush  out  1  insert bubble into ID/EX.
- ex_mem_flush  out  1  insert bubble into EX/MEM.
- mdu_start  out  1  one-cycle MDU start pulse.
- mdu_timeout_err  out  1  sticky error flag.
- stall_cnt  out  CNT_W  count of cycles with pc_stall=1.
- flush_cnt  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (asynchronous, rst=1):
  - MDU FSM goes to IDLE; both counters and mdu_timeout_err clear to 0.
  - While rst is high, every stall, flush and mdu_start output is 0.
- mem_stall = mem_req & ~dmem_ready.
  - Drives all five stall outputs to 1, with no flushes. This freezes the whole pipe and has the highest priority.
- MDU FSM, states IDLE, BUSY, DONE; transitions take effect on the clk edge:
  - IDLE: if ex_is_mdu and ~mem_stall, assert mdu_start combinationally this cycle and go to BUSY.
  - BUSY: stall PC, IF/ID, ID/EX and EX/MEM; assert ex_mem_flush so MEM receives bubbles.
    - On mdu_done, go to DONE.
    - When the busy count reaches MDU_TIMEOUT, set mdu_timeout_err and go to DONE.
  - DONE: the EX instruction advances; no MDU stall.
    - Leave to IDLE when ~mem_stall.
    - This state prevents re-issuing mdu_start for the same instruction.
  - The IDLE-cycle stall covers the start cycle: ex_is_mdu in IDLE also stalls PC, IF/ID and ID/EX, and asserts ex_mem_flush.
  - The busy counter resets on entry to BUSY.
- Load-use hazard (only when no MDU or mem stall is active):
  - Condition: ex_mem_read, ex_rd_addr≠0, and ex_rd_addr matches (id_uses_rs1 & rs1) or (id_uses_rs2 & rs2).
  - Response: for exactly one cycle, pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Branch taken (only when no mem stall and the MDU FSM is not in BUSY):
  - if_id_flush=1 and id_ex_flush=1; no stalls. A load-use stall in the same cycle is cancelled.
  - flush_cnt increments by 1.
- Priority: mem_stall > MDU > branch flush > load-use.
- Counters: stall_cnt increments on every cycle with pc_stall=1. Both counters wrap at 2^CNT_W.
- mdu_timeout_err clears only on reset.
- All outputs other than the counters and the error flag are combinational from the FSM state and the inputs: zero added latency.

Decomposition:
- Package hazard_pkg holds:
  - the MDU state enum (IDLE, BUSY, DONE);
  - the priority ordering constants;
  - the default MDU_TIMEOUT.
- One sub-module, mdu_seq, holds the MDU FSM, the busy counter and the timeout logic. It outputs mdu_start, mdu_stall and mdu_timeout_err.

Test Plan:
- Load x5 in EX (ex_rd_addr=5), ID reads rs2=x5 → one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle all 0; stall_cnt=1. The same case with ex_rd_addr=0 → no stall.
- ex_is_mdu=1 and mdu_done returned after 10 cycles → one mdu_start pulse, then pc_stall/ex_mem_flush held for 10 cycles plus the start cycle, then released; exactly one mdu_start overall.
- ex_is_mdu with no mdu_done → after 64 busy cycles mdu_timeout_err=1 (sticky) and the pipeline resumes.
- Branch taken coincident with a load-use match → if_id_flush=1 and id_ex_flush=1, no pc_stall; flush_cnt=1.
- mem_req=1 with dmem_ready low for 3 cycles while an MDU op is in BUSY and mdu_done fires in the middle → all stalls held, no second mdu_start, clean resume after dmem_ready.
- Assert rst mid-BUSY → all outputs 0 immediately, FSM in IDLE, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    // Lower value wins when several hazard sources are active together.
    localparam int PRIO_MEM      = 0;
    localparam int PRIO_MDU      = 1;
    localparam int PRIO_BRANCH   = 2;
    localparam int PRIO_LOAD_USE = 3;

    localparam int MDU_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// MDU start/done sequencer: issues one start per MDU instruction, stalls the
// front of the pipe while busy and flags a sticky error on timeout.
module mdu_seq
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_is_mdu,
    input  logic mdu_done,
    input  logic mem_stall,
    output logic mdu_start,
    output logic mdu_stall,
    output logic mdu_timeout_err
);

    localparam int BW = $clog2(MDU_TIMEOUT) + 1;

    mdu_state_t    state;
    logic [BW-1:0] busy_cnt;

    // The start cycle itself already holds the front end.
    assign mdu_start = ~rst & (state == MDU_IDLE) & ex_is_mdu & ~mem_stall;
    assign mdu_stall = (state == MDU_BUSY) | ((state == MDU_IDLE) & ex_is_mdu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= MDU_IDLE;
            busy_cnt        <= '0;
            mdu_timeout_err <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (mdu_start) begin
                        state    <= MDU_BUSY;
                        busy_cnt <= '0;
                    end
                end
                // done is a one-cycle pulse, so it is captured even under a mem stall
                MDU_BUSY: begin
                    if (mdu_done) begin
                        state <= MDU_DONE;
                    end else if (busy_cnt == BW'(MDU_TIMEOUT - 1)) begin
                        mdu_timeout_err <= 1'b1;
                        state           <= MDU_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (!mem_stall) state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core: memory wait states,
// MDU ops, taken branches and load-use hazards, plus performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_is_mdu,
    input  logic              ex_branch_taken,
    input  logic              mdu_done,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              mem_wb_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mdu_start,
    output logic              mdu_timeout_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic mem_stall;
    logic mdu_stall;
    logic load_use;
    logic br_flush;

    assign mem_stall = mem_req & ~dmem_ready;

    mdu_seq #(.MDU_TIMEOUT(MDU_TIMEOUT)) u_mdu_seq (
        .clk             (clk),
        .rst             (rst),
        .ex_is_mdu       (ex_is_mdu),
        .mdu_done        (mdu_done),
        .mem_stall       (mem_stall),
        .mdu_start       (mdu_start),
        .mdu_stall       (mdu_stall),
        .mdu_timeout_err (mdu_timeout_err)
    );

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read & (ex_rd_addr != '0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        br_flush     = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
            end else if (mdu_stall) begin
                {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                br_flush    = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(pc_stall);
            flush_cnt <= flush_cnt + CNT_W'(br_flush);
        end
    end

endmodule
